booth_seq_mult: RTL

//   Sequential radix-2 Booth multiplier, 32x32 signed -> 32-bit product plus overflow flag.

---
 rtl/booth_seq_mult_pkg.sv | 18 +
 rtl/booth_seq_mult_ppa.sv | 36 +++
 rtl/booth_seq_mult.sv | 115 +++++++++++
 3 files changed

// File: rtl/booth_seq_mult_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
package booth_seq_mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_ITERS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Product fits in 32 signed bits only when bits [63:31] are all equal.
  function automatic logic prod_ovf(input logic [MULT_WIDTH-1:0] hi, input logic lo_sign);
    return ~((&{hi, lo_sign}) | ~(|{hi, lo_sign}));
  endfunction

endpackage

// File: rtl/booth_seq_mult_ppa.sv
// 32-bit Kogge-Stone parallel prefix adder with carry-in; provides sum, carry-out and signed overflow.
module booth_seq_mult_ppa #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ovf
);

  localparam int LEVELS = $clog2(W);

  logic [W-1:0] prop;
  logic [W-1:0] gk;
  logic [W-1:0] pk;
  logic [W:0]   c;

  always_comb begin
    prop = a ^ b;
    gk   = a & b;
    pk   = a ^ b;
    // Group propagate shifts in ones below bit 0 so cin can ripple through the whole prefix.
    for (int l = 0; l < LEVELS; l++) begin
      gk = gk | (pk & (gk << (1 << l)));
      pk = pk & ((pk << (1 << l)) | ~({W{1'b1}} << (1 << l)));
    end
    c = {gk | (pk & {W{cin}}), cin};
  end

  assign s    = prop ^ c[W-1:0];
  assign cout = c[W];
  assign ovf  = c[W] ^ c[W-1];

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: 32x32 signed -> low 32-bit product plus overflow flag.
//
//   state   | meaning
//   IDLE    | waiting for start; operands latched on accept
//   RUN     | one Booth add/sub + arithmetic shift per cycle, 32 cycles
//   DONE    | one-cycle done pulse; P/ovf already registered
module booth_seq_mult
  import booth_seq_mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] P,
  output logic             ovf
);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   acc, q, m;
  logic               q_m1;
  logic [CNT_W-1:0]   count;

  logic [WIDTH-1:0]   addend, sum, acc_sel, acc_shift, q_shift;
  logic               add_cin, add_ovf, do_add, acc_sign, last_iter;
  logic               ppa_cout_unused;

  always_comb begin
    addend  = m;
    add_cin = 1'b0;
    if ({q[0], q_m1} == 2'b10) begin
      addend  = ~m;
      add_cin = 1'b1;
    end
  end

  booth_seq_mult_ppa #(.W(WIDTH)) u_my_ppa (
    .a    (acc),
    .b    (addend),
    .cin  (add_cin),
    .s    (sum),
    .cout (ppa_cout_unused),
    .ovf  (add_ovf)
  );

  // Shifted-in sign is the true sum sign so M = 0x80000000 subtracts correctly.
  assign do_add    = q[0] ^ q_m1;
  assign acc_sel   = do_add ? sum : acc;
  assign acc_sign  = do_add ? (sum[WIDTH-1] ^ add_ovf) : acc[WIDTH-1];
  assign acc_shift = {acc_sign, acc_sel[WIDTH-1:1]};
  assign q_shift   = {acc_sel[0], q[WIDTH-1:1]};
  assign last_iter = (count == CNT_W'(MULT_ITERS - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last_iter) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_RUN) || (state == ST_DONE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc   <= '0;
      q     <= '0;
      q_m1  <= 1'b0;
      m     <= '0;
      count <= '0;
      P     <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            m     <= A;
            q     <= B;
            acc   <= '0;
            q_m1  <= 1'b0;
            count <= '0;
          end
        end
        ST_RUN: begin
          acc   <= acc_shift;
          q     <= q_shift;
          q_m1  <= q[0];
          count <= count + 1'b1;
          if (last_iter) begin
            P   <= q_shift;
            ovf <= prod_ovf(acc_shift, q_shift[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
